// File: rtl/sd_sector_fifo_pkg.sv
// Shared constants for the SD sector FIFO.
// Direction encodings and default depth.
package sd_sector_fifo_pkg;

  localparam logic DIR_DISK2HOST = 1'b0;
  localparam logic DIR_HOST2DISK = 1'b1;

  localparam int DEPTH_LOG2_DEF = 8;

endpackage

// File: rtl/sd_fifo_mem.sv
// 32-bit simple dual-port word store, registered read.
// A same-address write is returned on the read port.
module sd_fifo_mem #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [0:(1<<AW)-1];

  // write port plus write-first registered read
  always_ff @(posedge clk) begin
    if (we)
      mem[waddr] <= wdata;
    if (we && (waddr == raddr))
      rdata <= wdata;
    else
      rdata <= mem[raddr];
  end

endmodule

// File: rtl/sd_sector_fifo.sv
// Sector FIFO between an SD Avalon master and a 16-bit host port.
// Define SD_FIFO_ERR_EN to build the sticky protocol error flag.
module sd_sector_fifo
  import sd_sector_fifo_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                dir,
  input  logic                flush,
  input  logic [31:0]         sd_address,
  input  logic                sd_write,
  input  logic [31:0]         sd_writedata,
  input  logic                sd_read,
  output logic                sd_waitrequest,
  output logic [31:0]         sd_readdata,
  output logic                sd_readdatavalid,
  input  logic                host_wr,
  input  logic [15:0]         host_wdata,
  input  logic                host_rd,
  output logic [15:0]         host_rdata,
  output logic                host_rd_ready,
  output logic                host_wr_ready,
  output logic [DEPTH_LOG2:0] level,
  output logic                err
);

  localparam int AW = DEPTH_LOG2;
  localparam int LW = DEPTH_LOG2 + 1;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_ptr_nxt;
  logic          dir_q;
  logic          rd_phase;
  logic          wr_phase;
  logic [15:0]   wr_lo;
  logic [31:0]   head;
  logic [31:0]   push_data;

  logic d2h, h2d, clr;
  logic full, empty;
  logic hrd_ok, hwr_ok;
  logic sd_push, sd_pop;
  logic host_push, host_pop;
  logic push, pop;

  logic unused;
  assign unused = ^sd_address;

  assign d2h   = (dir == DIR_DISK2HOST);
  assign h2d   = (dir == DIR_HOST2DISK);
  assign clr   = flush | (dir != dir_q);
  assign full  = level[DEPTH_LOG2];
  assign empty = (level == '0);

  assign sd_waitrequest = (d2h & sd_write & full)
                        | (h2d & sd_read & empty);

  assign host_rd_ready = d2h & ~empty;
  assign host_wr_ready = h2d & ~full;

  assign hrd_ok    = host_rd & host_rd_ready & ~clr;
  assign hwr_ok    = host_wr & host_wr_ready & ~clr;
  assign sd_push   = ~clr & d2h & sd_write & ~full;
  assign sd_pop    = ~clr & h2d & sd_read & ~empty;
  assign host_push = hwr_ok & wr_phase;
  assign host_pop  = hrd_ok & rd_phase;
  assign push      = sd_push | host_push;
  assign pop       = sd_pop | host_pop;

  assign push_data = h2d ? {host_wdata, wr_lo}
                         : sd_writedata;

  assign host_rdata = ~host_rd_ready ? 16'h0 :
                      rd_phase ? head[31:16] :
                                 head[15:0];

  // read address tracks the head for the next cycle
  always_comb begin
    rd_ptr_nxt = rd_ptr;
    if (clr)
      rd_ptr_nxt = '0;
    else if (pop)
      rd_ptr_nxt = rd_ptr + AW'(1);
  end

  sd_fifo_mem #(
    .AW(AW)
  ) u_mem (
    .clk  (clk),
    .we   (push),
    .waddr(wr_ptr),
    .wdata(push_data),
    .raddr(rd_ptr_nxt),
    .rdata(head)
  );

  // remember direction so a flip can clear the FIFO
  always_ff @(posedge clk) begin
    dir_q <= dir;
  end

  // pointers, level and half-word phases
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      rd_phase <= 1'b0;
      wr_phase <= 1'b0;
      wr_lo    <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= rd_ptr_nxt;
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      if (hrd_ok)
        rd_phase <= ~rd_phase;
      if (hwr_ok) begin
        wr_phase <= ~wr_phase;
        if (!wr_phase)
          wr_lo <= host_wdata;
      end
    end
  end

  // Avalon read response, one cycle after acceptance
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sd_readdatavalid <= 1'b0;
      sd_readdata      <= '0;
    end else begin
      sd_readdatavalid <= sd_pop;
      if (sd_pop)
        sd_readdata <= head;
    end
  end

`ifdef SD_FIFO_ERR_EN
  logic err_set;

  assign err_set = (host_rd & ~host_rd_ready)
                 | (host_wr & ~host_wr_ready)
                 | (d2h & sd_read)
                 | (h2d & sd_write);

  // sticky protocol error, cleared by flush
  always_ff @(posedge clk) begin
    if (!rst_n)
      err <= 1'b0;
    else if (flush)
      err <= 1'b0;
    else if (err_set)
      err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_sd_sector_fifo.sv
// Bench for sd_sector_fifo: vector table, directed
// corners and random traffic against a queue model.
module tb_sd_sector_fifo;

  localparam int DEPTH = 256;
`ifdef SD_FIFO_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef struct {
    logic        rst_n;
    logic        dir;
    logic        fl;
    logic        sdw;
    logic [31:0] sdwd;
    logic        sdr;
    logic        hw;
    logic [15:0] hwd;
    logic        hr;
  } in_t;

  typedef struct {
    in_t         i;
    logic [31:0] lvl;
    logic [31:0] hrd;
    logic        wq;
    logic        hrr;
    logic        hwr;
    logic        rv;
    logic [31:0] rd;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        dir;
  logic        flush;
  logic [31:0] sd_address;
  logic        sd_write;
  logic [31:0] sd_writedata;
  logic        sd_read;
  logic        sd_waitrequest;
  logic [31:0] sd_readdata;
  logic        sd_readdatavalid;
  logic        host_wr;
  logic [15:0] host_wdata;
  logic        host_rd;
  logic [15:0] host_rdata;
  logic        host_rd_ready;
  logic        host_wr_ready;
  logic [8:0]  level;
  logic        err;

  sd_sector_fifo #(
    .DEPTH_LOG2(8)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .dir             (dir),
    .flush           (flush),
    .sd_address      (sd_address),
    .sd_write        (sd_write),
    .sd_writedata    (sd_writedata),
    .sd_read         (sd_read),
    .sd_waitrequest  (sd_waitrequest),
    .sd_readdata     (sd_readdata),
    .sd_readdatavalid(sd_readdatavalid),
    .host_wr         (host_wr),
    .host_wdata      (host_wdata),
    .host_rd         (host_rd),
    .host_rdata      (host_rdata),
    .host_rd_ready   (host_rd_ready),
    .host_wr_ready   (host_wr_ready),
    .level           (level),
    .err             (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] a_lvl, a_hrd, a_rd;
  logic        a_wq, a_hrr, a_hwr, a_rv, a_err;

  bit [31:0] mq[$];
  bit        m_rph, m_wph, m_pv, m_err, m_dprev;
  bit [15:0] m_lo;
  bit [31:0] m_pd;

  vec_t tbl[$];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  function automatic in_t vin(
    input logic rs, input logic d, input logic fl,
    input logic sw, input logic [31:0] swd,
    input logic sr, input logic hw,
    input logic [15:0] hwd, input logic hr);
    in_t v;
    v.rst_n = rs; v.dir = d; v.fl = fl;
    v.sdw = sw; v.sdwd = swd; v.sdr = sr;
    v.hw = hw; v.hwd = hwd; v.hr = hr;
    return v;
  endfunction

  task automatic add(input in_t v,
                     input logic [31:0] lvl,
                     input logic [31:0] hrd,
                     input logic wq, input logic hrr,
                     input logic hwr, input logic rv,
                     input logic [31:0] rd);
    vec_t e;
    e.i = v; e.lvl = lvl; e.hrd = hrd; e.wq = wq;
    e.hrr = hrr; e.hwr = hwr; e.rv = rv; e.rd = rd;
    tbl.push_back(e);
  endtask

  // compare DUT against the model state for this cycle
  task automatic model_check(input in_t v);
    int  n;
    bit  full, empty, e_wq, e_hrr, e_hwr;
    bit  [31:0] hd;
    logic [31:0] e_hrd;
    n     = mq.size();
    full  = (n == DEPTH);
    empty = (n == 0);
    e_wq  = (!v.dir && v.sdw && full) ||
            (v.dir && v.sdr && empty);
    e_hrr = !v.dir && !empty;
    e_hwr = v.dir && !full;
    chk("m_level", a_lvl, 32'(n));
    chk("m_waitreq", 32'(a_wq), 32'(e_wq));
    chk("m_rd_ready", 32'(a_hrr), 32'(e_hrr));
    chk("m_wr_ready", 32'(a_hwr), 32'(e_hwr));
    chk("m_rvalid", 32'(a_rv), 32'(m_pv));
    chk("m_err", 32'(a_err), 32'(m_err));
    if (e_hrr) begin
      hd    = mq[0];
      e_hrd = m_rph ? 32'(hd[31:16]) : 32'(hd[15:0]);
      chk("m_host_rdata", a_hrd, e_hrd);
    end
    if (m_pv)
      chk("m_readdata", a_rd, m_pd);
  endtask

  // advance the model across the coming clock edge
  task automatic model_step(input in_t v);
    bit        full, empty, hrr, hwr, clr;
    bit        do_pop, do_push, set;
    bit [31:0] pw, w;
    if (!v.rst_n) begin
      mq.delete();
      m_rph = 0; m_wph = 0; m_pv = 0;
      m_pd = 0; m_err = 0; m_dprev = v.dir;
      return;
    end
    full  = (mq.size() == DEPTH);
    empty = (mq.size() == 0);
    hrr   = !v.dir && !empty;
    hwr   = v.dir && !full;
    clr   = v.fl || (v.dir != m_dprev);
    m_dprev = v.dir;
    set = (v.hr && !hrr) || (v.hw && !hwr) ||
          (!v.dir && v.sdr) || (v.dir && v.sdw);
    if (ERR_EN) begin
      if (v.fl) m_err = 0;
      else if (set) m_err = 1;
    end
    m_pv = 0;
    if (clr) begin
      mq.delete();
      m_rph = 0; m_wph = 0;
      return;
    end
    do_pop = 0; do_push = 0; pw = 0;
    if (!v.dir) begin
      if (v.sdw && !full) begin
        do_push = 1; pw = v.sdwd;
      end
      if (v.hr && hrr) begin
        if (m_rph) do_pop = 1;
        m_rph = !m_rph;
      end
    end else begin
      if (v.sdr && !empty) begin
        do_pop = 1; m_pv = 1;
      end
      if (v.hw && hwr) begin
        if (m_wph) begin
          do_push = 1; pw = {v.hwd, m_lo};
        end else begin
          m_lo = v.hwd;
        end
        m_wph = !m_wph;
      end
    end
    if (do_pop) begin
      w = mq.pop_front();
      if (m_pv) m_pd = w;
    end
    if (do_push) mq.push_back(pw);
  endtask

  // one clock: drive, sample, check, update model
  task automatic cyc(input in_t v);
    @(negedge clk);
    rst_n = v.rst_n; dir = v.dir; flush = v.fl;
    sd_address = $urandom;
    sd_write = v.sdw; sd_writedata = v.sdwd;
    sd_read = v.sdr;
    host_wr = v.hw; host_wdata = v.hwd;
    host_rd = v.hr;
    #1;
    a_lvl = 32'(level); a_hrd = 32'(host_rdata);
    a_wq = sd_waitrequest; a_hrr = host_rd_ready;
    a_hwr = host_wr_ready; a_rv = sd_readdatavalid;
    a_rd = sd_readdata; a_err = err;
    model_check(v);
    model_step(v);
    @(posedge clk);
  endtask

  in_t rv_in;
  int  wp, rp;
  logic rdir;

  initial begin
    rst_n = 1'b0; dir = 1'b0; flush = 1'b0;
    sd_address = '0; sd_write = 1'b0;
    sd_writedata = '0; sd_read = 1'b0;
    host_wr = 1'b0; host_wdata = '0; host_rd = 1'b0;
    mq.delete();
    m_rph = 0; m_wph = 0; m_pv = 0; m_pd = 0;
    m_err = 0; m_dprev = 0; m_lo = 0;

    // rst dir fl sdw sdwd sdr hw hwd hr
    // exp: lvl hrd wq hrr hwr rv rd
    add(vin(0,0,0,0,0,0,0,0,0), 0,0,0,0,0,0,0);
    add(vin(1,0,0,1,32'h11223344,0,0,0,0),
        0,0,0,0,0,0,0);
    add(vin(1,0,0,0,0,0,0,0,1),
        1,32'h3344,0,1,0,0,0);
    add(vin(1,0,0,0,0,0,0,0,1),
        1,32'h1122,0,1,0,0,0);
    add(vin(1,0,0,0,0,0,0,0,0), 0,0,0,0,0,0,0);
    add(vin(1,0,0,0,0,1,0,0,0), 0,0,0,0,0,0,0);
    add(vin(1,1,0,0,0,0,0,0,0), 0,0,0,0,1,0,0);
    add(vin(1,1,0,0,0,0,1,16'hBEEF,0),
        0,0,0,0,1,0,0);
    add(vin(1,1,0,0,0,0,1,16'hDEAD,0),
        0,0,0,0,1,0,0);
    add(vin(1,1,0,0,0,1,0,0,0), 1,0,0,0,1,0,0);
    add(vin(1,1,0,0,0,0,0,0,0),
        0,0,0,0,1,1,32'hDEADBEEF);
    add(vin(1,1,0,0,0,1,0,0,0), 0,0,1,0,1,0,0);
    add(vin(1,1,0,0,0,1,1,16'h1111,0),
        0,0,1,0,1,0,0);
    add(vin(1,1,0,0,0,1,1,16'h2222,0),
        0,0,1,0,1,0,0);
    add(vin(1,1,0,0,0,1,0,0,0), 1,0,0,0,1,0,0);
    add(vin(1,1,0,0,0,0,0,0,0),
        0,0,0,0,1,1,32'h22221111);
    add(vin(1,1,0,0,0,0,1,16'h0001,0),
        0,0,0,0,1,0,0);
    add(vin(1,1,0,0,0,0,1,16'h0002,0),
        0,0,0,0,1,0,0);
    add(vin(1,1,0,0,0,0,1,16'h0003,0),
        1,0,0,0,1,0,0);
    add(vin(1,1,0,0,0,0,1,16'h0004,0),
        1,0,0,0,1,0,0);
    add(vin(1,1,0,0,0,0,1,16'h0005,0),
        2,0,0,0,1,0,0);
    add(vin(1,1,0,0,0,0,1,16'h0006,0),
        2,0,0,0,1,0,0);
    add(vin(1,1,0,0,0,0,1,16'h0007,0),
        3,0,0,0,1,0,0);
    add(vin(1,1,1,0,0,0,0,0,0), 3,0,0,0,1,0,0);
    add(vin(1,1,0,0,0,0,0,0,0), 0,0,0,0,1,0,0);
    add(vin(1,1,0,0,0,0,1,16'hAAAA,0),
        0,0,0,0,1,0,0);
    add(vin(1,1,0,0,0,0,1,16'hBBBB,0),
        0,0,0,0,1,0,0);
    add(vin(1,1,0,0,0,1,0,0,0), 1,0,0,0,1,0,0);
    add(vin(1,1,1,0,0,0,0,0,0),
        0,0,0,0,1,1,32'hBBBBAAAA);
    add(vin(1,1,0,0,0,0,0,0,0), 0,0,0,0,1,0,0);

    foreach (tbl[k]) begin
      cyc(tbl[k].i);
      chk($sformatf("tv%0d_level", k),
          a_lvl, tbl[k].lvl);
      chk($sformatf("tv%0d_waitreq", k),
          32'(a_wq), 32'(tbl[k].wq));
      chk($sformatf("tv%0d_rd_ready", k),
          32'(a_hrr), 32'(tbl[k].hrr));
      chk($sformatf("tv%0d_wr_ready", k),
          32'(a_hwr), 32'(tbl[k].hwr));
      chk($sformatf("tv%0d_rvalid", k),
          32'(a_rv), 32'(tbl[k].rv));
      if (tbl[k].rv || !tbl[k].i.rst_n)
        chk($sformatf("tv%0d_readdata", k),
            a_rd, tbl[k].rd);
      if (tbl[k].hrr || !tbl[k].i.rst_n)
        chk($sformatf("tv%0d_host_rdata", k),
            a_hrd, tbl[k].hrd);
    end

    // fill to full, then stall until a host pop
    cyc(vin(1,0,0,0,0,0,0,0,0));
    for (int i = 0; i < DEPTH; i++)
      cyc(vin(1,0,0,1,32'hA5000000 | i,0,0,0,0));
    cyc(vin(1,0,0,1,32'h5A5A5A5A,0,0,0,0));
    chk("full_level", a_lvl, 32'd256);
    chk("full_wait", 32'(a_wq), 32'd1);
    cyc(vin(1,0,0,1,32'h5A5A5A5A,0,0,0,1));
    chk("full_wait_rd1", 32'(a_wq), 32'd1);
    chk("full_lo", a_hrd, 32'h0000);
    cyc(vin(1,0,0,1,32'h5A5A5A5A,0,0,0,1));
    chk("full_wait_rd2", 32'(a_wq), 32'd1);
    chk("full_hi", a_hrd, 32'hA500);
    cyc(vin(1,0,0,1,32'h5A5A5A5A,0,0,0,0));
    chk("after_pop_wait", 32'(a_wq), 32'd0);
    chk("after_pop_level", a_lvl, 32'd255);
    cyc(vin(1,0,0,0,0,0,0,0,0));
    chk("refill_level", a_lvl, 32'd256);

    // sticky error from host read while empty
    cyc(vin(1,0,1,0,0,0,0,0,0));
    cyc(vin(1,0,0,0,0,0,0,0,0));
    chk("err_clear0", 32'(a_err), 32'd0);
    chk("err_empty", a_lvl, 32'd0);
    cyc(vin(1,0,0,0,0,0,0,0,1));
    cyc(vin(1,0,0,0,0,0,0,0,0));
    chk("err_set", 32'(a_err), 32'(ERR_EN));
    cyc(vin(1,0,0,0,0,0,0,0,0));
    chk("err_hold", 32'(a_err), 32'(ERR_EN));
    cyc(vin(1,0,1,0,0,0,0,0,0));
    cyc(vin(1,0,0,0,0,0,0,0,0));
    chk("err_flushed", 32'(a_err), 32'd0);

    // random traffic against the model
    cyc(vin(0,0,0,0,0,0,0,0,0));
    rdir = 1'b0;
    wp = 50; rp = 50;
    for (int i = 0; i < 4000; i++) begin
      if (i % 250 == 0) begin
        wp = $urandom_range(0, 100);
        rp = $urandom_range(0, 100);
      end
      if ($urandom_range(0, 79) == 0) rdir = ~rdir;
      rv_in.rst_n = ($urandom_range(0, 599) != 0);
      rv_in.dir   = rdir;
      rv_in.fl    = ($urandom_range(0, 99) == 0);
      rv_in.sdw   = ($urandom_range(0, 99) < wp);
      rv_in.sdwd  = $urandom;
      rv_in.sdr   = ($urandom_range(0, 99) < rp);
      rv_in.hw    = ($urandom_range(0, 99) < wp);
      rv_in.hwd   = 16'($urandom);
      rv_in.hr    = ($urandom_range(0, 99) < rp);
      cyc(rv_in);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
